// File: rtl/system_qsy_nios2_qsys_oci_dct_ctrl.sv
// OCI debug-capture-trace sequencer: packs 2-bit atoms into 30-bit frames and hands them off.
// Optional idle auto-flush is enabled by defining OCI_DCT_TIMEOUT_EN.
module system_qsy_nios2_qsys_oci_dct_ctrl #(
  parameter int unsigned ATOM_W  = 2,
  parameter int unsigned ATOMS   = 15,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      atom_valid,
  input  logic [ATOM_W-1:0]         atom_data,
  output logic                      atom_ready,
  input  logic                      flush_req,
  input  logic                      test_ending,
  output logic                      frame_valid,
  output logic [ATOM_W*ATOMS-1:0]   frame_data,
  output logic [CNT_W-1:0]          frame_count,
  input  logic                      frame_ready,
  output logic [ATOM_W*ATOMS-1:0]   dct_buffer,
  output logic [CNT_W-1:0]          dct_count,
  output logic                      test_has_ended,
  output logic                      atom_dropped
);

  localparam int unsigned BUF_W = ATOM_W * ATOMS;

  typedef enum logic [1:0] {StRun, StDrain, StEnded} state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d, frame_data_q, frame_data_d, buf_shift;
  logic [CNT_W-1:0]   cnt_q, cnt_d, frame_count_q, frame_count_d, cnt_inc;
  logic               frame_valid_q, frame_valid_d;
  logic               pend_q, pend_d, dropped_q, dropped_d;
  logic               accept, cnt_last, frame_free, full, nonempty;
  logic               flush_trig, pend_now, flush_load, load, timeout_trig;

`ifdef OCI_DCT_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              idle_run;

  // Saturates at TIMEOUT-1 so a blocked auto-flush stays requested.
  always_comb begin
    idle_run     = (state_q == StRun) && (cnt_q != '0) && !accept;
    timeout_trig = idle_run && (idle_q == IDLE_W'(TIMEOUT - 1));
    idle_d       = '0;
    if (idle_run && !load) begin
      idle_d = timeout_trig ? idle_q : idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  assign timeout_trig = 1'b0 && (TIMEOUT != 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StRun;
      buf_q         <= '0;
      cnt_q         <= '0;
      frame_data_q  <= '0;
      frame_count_q <= '0;
      frame_valid_q <= 1'b0;
      pend_q        <= 1'b0;
      dropped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      buf_q         <= buf_d;
      cnt_q         <= cnt_d;
      frame_data_q  <= frame_data_d;
      frame_count_q <= frame_count_d;
      frame_valid_q <= frame_valid_d;
      pend_q        <= pend_d;
      dropped_q     <= dropped_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (test_ending) state_d = StDrain;
      StDrain: if ((cnt_q == '0) && !frame_valid_q) state_d = StEnded;
      StEnded: state_d = StEnded;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    accept     = atom_valid && atom_ready;
    cnt_last   = (cnt_q == CNT_W'(ATOMS - 1));
    frame_free = !frame_valid_q || frame_ready;
    buf_shift  = {buf_q[BUF_W-ATOM_W-1:0], atom_data};
    cnt_inc    = cnt_q + 1'b1;
    full       = accept && cnt_last;
    nonempty   = (cnt_q != '0) || accept;
    flush_trig = flush_req || (state_q == StDrain) || timeout_trig;
    pend_now   = pend_q || (flush_trig && nonempty);
    flush_load = pend_now && nonempty && frame_free;
    // A full buffer implies a free frame register: atom_ready is low otherwise.
    load       = full || flush_load;

    frame_data_d  = frame_data_q;
    frame_count_d = frame_count_q;
    buf_d         = accept ? buf_shift : buf_q;
    cnt_d         = accept ? cnt_inc : cnt_q;
    if (load) begin
      frame_data_d  = buf_d;
      frame_count_d = cnt_d;
      buf_d         = '0;
      cnt_d         = '0;
    end
    frame_valid_d = load || (frame_valid_q && !frame_ready);
    pend_d        = pend_now && !load;
    dropped_d     = dropped_q || (atom_valid && (state_q != StRun));
  end

  always_comb begin
    atom_ready     = (state_q == StRun) && !(cnt_last && frame_valid_q && !frame_ready);
    test_has_ended = (state_q == StEnded);
    frame_valid    = frame_valid_q;
    frame_data     = frame_data_q;
    frame_count    = frame_count_q;
    dct_buffer     = buf_q;
    dct_count      = cnt_q;
    atom_dropped   = dropped_q;
  end

endmodule
